// File: rtl/countdown_timer.sv
// Down-counting mm:ss.hh timer with preset load, pause/resume, expiry pulse and blinking alarm.
// Count updates on the tick edge; display registers trail the count by one cycle unless held.
module countdown_timer #(
  parameter int ALARM_HALF_PERIOD = 50
) (
  input  logic       CLK_50MHz,
  input  logic       reset,
  input  logic       tick_100Hz,
  input  logic       load,
  input  logic [6:0] preset_mins,
  input  logic [5:0] preset_secs,
  input  logic [6:0] preset_decs,
  input  logic       start_stop,
  input  logic       hold,
  output logic [6:0] timer_unit_mins,
  output logic [5:0] timer_unit_secs,
  output logic [6:0] timer_unit_decs,
  output logic       running,
  output logic       expired,
  output logic       done_pulse,
  output logic       alarm
);

  localparam logic [5:0] ALARM_LAST = 6'(ALARM_HALF_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, EXPIRED} state_t;

  state_t     state_p0, state_nxt;
  logic [6:0] cnt_mins_p0, cnt_mins_nxt;
  logic [5:0] cnt_secs_p0, cnt_secs_nxt;
  logic [6:0] cnt_decs_p0, cnt_decs_nxt;
  logic       done_p0, done_nxt;
  logic       alarm_p0, alarm_nxt;
  logic [5:0] alarm_cnt_p0, alarm_cnt_nxt;
  logic [6:0] disp_mins_p1;
  logic [5:0] disp_secs_p1;
  logic [6:0] disp_decs_p1;
  logic       cnt_zero;
  logic       cnt_last;

  function automatic logic [6:0] sat_99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [5:0] sat_59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  assign cnt_zero = (cnt_mins_p0 == 7'd0) && (cnt_secs_p0 == 6'd0) && (cnt_decs_p0 == 7'd0);
  assign cnt_last = (cnt_mins_p0 == 7'd0) && (cnt_secs_p0 == 6'd0) && (cnt_decs_p0 == 7'd1);

  always_comb begin
    state_nxt     = state_p0;
    cnt_mins_nxt  = cnt_mins_p0;
    cnt_secs_nxt  = cnt_secs_p0;
    cnt_decs_nxt  = cnt_decs_p0;
    done_nxt      = 1'b0;
    alarm_nxt     = 1'b0;
    alarm_cnt_nxt = 6'd0;
    case (state_p0)
      IDLE: begin
        if (load) begin
          cnt_mins_nxt = sat_99(preset_mins);
          cnt_secs_nxt = sat_59(preset_secs);
          cnt_decs_nxt = sat_99(preset_decs);
        end else if (start_stop && !cnt_zero) begin
          state_nxt = RUNNING;
        end
      end
      RUNNING: begin
        // Stop has priority over a coincident tick; load is ignored while running.
        if (start_stop) begin
          state_nxt = IDLE;
        end else if (tick_100Hz && !cnt_zero) begin
          if (cnt_decs_p0 != 7'd0) begin
            cnt_decs_nxt = cnt_decs_p0 - 7'd1;
          end else begin
            cnt_decs_nxt = 7'd99;
            if (cnt_secs_p0 != 6'd0) begin
              cnt_secs_nxt = cnt_secs_p0 - 6'd1;
            end else begin
              cnt_secs_nxt = 6'd59;
              cnt_mins_nxt = cnt_mins_p0 - 7'd1;
            end
          end
          if (cnt_last) begin
            state_nxt = EXPIRED;
            done_nxt  = 1'b1;
            alarm_nxt = 1'b1;
          end
        end
      end
      EXPIRED: begin
        if (load) begin
          state_nxt    = IDLE;
          cnt_mins_nxt = sat_99(preset_mins);
          cnt_secs_nxt = sat_59(preset_secs);
          cnt_decs_nxt = sat_99(preset_decs);
        end else if (start_stop) begin
          state_nxt = IDLE;
        end else begin
          alarm_nxt     = alarm_p0;
          alarm_cnt_nxt = alarm_cnt_p0;
          if (tick_100Hz) begin
            if (alarm_cnt_p0 == ALARM_LAST) begin
              alarm_nxt     = ~alarm_p0;
              alarm_cnt_nxt = 6'd0;
            end else begin
              alarm_cnt_nxt = alarm_cnt_p0 + 6'd1;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: state, count and alarm registers; stage p1: display registers.
  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      state_p0     <= IDLE;
      cnt_mins_p0  <= 7'd0;
      cnt_secs_p0  <= 6'd0;
      cnt_decs_p0  <= 7'd0;
      done_p0      <= 1'b0;
      alarm_p0     <= 1'b0;
      alarm_cnt_p0 <= 6'd0;
      disp_mins_p1 <= 7'd0;
      disp_secs_p1 <= 6'd0;
      disp_decs_p1 <= 7'd0;
    end else begin
      state_p0     <= state_nxt;
      cnt_mins_p0  <= cnt_mins_nxt;
      cnt_secs_p0  <= cnt_secs_nxt;
      cnt_decs_p0  <= cnt_decs_nxt;
      done_p0      <= done_nxt;
      alarm_p0     <= alarm_nxt;
      alarm_cnt_p0 <= alarm_cnt_nxt;
      if (!hold) begin
        disp_mins_p1 <= cnt_mins_p0;
        disp_secs_p1 <= cnt_secs_p0;
        disp_decs_p1 <= cnt_decs_p0;
      end
    end
  end

  assign timer_unit_mins = disp_mins_p1;
  assign timer_unit_secs = disp_secs_p1;
  assign timer_unit_decs = disp_decs_p1;
  assign running         = (state_p0 == RUNNING);
  assign expired         = (state_p0 == EXPIRED);
  assign done_pulse      = done_p0;
  assign alarm           = alarm_p0;

endmodule
